// File: rtl/irda_sir_if.sv
// UART-side / IR-side signal bundle for one IrDA SIR codec channel.
interface irda_sir_if;
  logic [15:0] div;
  logic        tx_nrz;
  logic        ir_tx;
  logic        tx_busy;
  logic        ir_rx;
  logic        rx_nrz;

  modport master (output div, tx_nrz, ir_rx, input ir_tx, tx_busy, rx_nrz);
  modport slave  (input div, tx_nrz, ir_rx, output ir_tx, tx_busy, rx_nrz);
endinterface

// File: rtl/irda_sir_codec.sv
// IrDA SIR 3/16 modulator/demodulator for one UART channel.
// Optional IRDA_ECHO_SUPPRESS_EN blanks RX while (and 16 rx ticks after) TX is busy.
module irda_sir_codec #(
  parameter bit RX_ACTIVE_LOW = 1'b1,
  parameter int PULSE_TICKS   = 3,
  parameter int MIN_PULSE_CLK = 2
) (
  input  logic       clk,
  input  logic       reset,
  irda_sir_if.slave  bus
);
  localparam int FW = $clog2(MIN_PULSE_CLK + 1);
  localparam logic [FW-1:0] FMAX = FW'(MIN_PULSE_CLK);
  localparam logic [FW-1:0] FDET = FW'(MIN_PULSE_CLK - 1);
  localparam logic [4:0]    PW   = 5'(PULSE_TICKS);

  typedef enum logic {TX_IDLE, TX_ZERO} tx_state_t;

  // >= rather than == so a lowered divisor takes effect without a full wrap
  logic [15:0] div_m1;
  logic [15:0] tx_cnt, rx_cnt;
  logic        tx_tick, rx_tick;
  assign div_m1  = (bus.div == 16'd0) ? 16'd0 : bus.div - 16'd1;
  assign tx_tick = (tx_cnt >= div_m1);
  assign rx_tick = (rx_cnt >= div_m1);

  // ---------------- TX ----------------
  tx_state_t   tx_st;
  logic        tx_s1, tx_s, tx_d;
  logic [3:0]  phase, phase_nx;
  logic        ir_tx_q, busy_q;
  assign phase_nx = tx_tick ? phase + 4'd1 : phase;

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_s1   <= 1'b1;
      tx_s    <= 1'b1;
      tx_d    <= 1'b1;
      tx_st   <= TX_IDLE;
      phase   <= 4'd0;
      tx_cnt  <= 16'd0;
      ir_tx_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      tx_s1 <= bus.tx_nrz;
      tx_s  <= tx_s1;
      tx_d  <= tx_s;
      case (tx_st)
        TX_IDLE: begin
          tx_cnt <= 16'd0;
          phase  <= 4'd0;
          if (tx_d && !tx_s) begin
            tx_st   <= TX_ZERO;
            ir_tx_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        TX_ZERO: begin
          if (tx_s) begin
            // line back high: drop the pulse even if it is cut short
            tx_st   <= TX_IDLE;
            ir_tx_q <= 1'b0;
            busy_q  <= 1'b0;
            tx_cnt  <= 16'd0;
            phase   <= 4'd0;
          end else begin
            tx_cnt  <= tx_tick ? 16'd0 : tx_cnt + 16'd1;
            phase   <= phase_nx;
            ir_tx_q <= ({1'b0, phase_nx} < PW);
          end
        end
        default: tx_st <= TX_IDLE;
      endcase
    end
  end

  // ---------------- RX ----------------
  logic          ir_s1, ir_s, act, blk, detect;
  logic [FW-1:0] fcnt;
  logic [3:0]    win;
  logic          rx_q;
  assign act    = ir_s ^ RX_ACTIVE_LOW;
  assign detect = act && !blk && (fcnt == FDET);

`ifdef IRDA_ECHO_SUPPRESS_EN
  logic [4:0] esc;
  always_ff @(posedge clk) begin
    if (reset)                   esc <= 5'd0;
    else if (busy_q)             esc <= 5'd16;
    else if (esc != 5'd0 && rx_tick) esc <= esc - 5'd1;
  end
  assign blk = busy_q || (esc != 5'd0);
`else
  assign blk = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      ir_s1  <= RX_ACTIVE_LOW;
      ir_s   <= RX_ACTIVE_LOW;
      fcnt   <= '0;
      rx_cnt <= 16'd0;
      win    <= 4'd0;
      rx_q   <= 1'b1;
    end else begin
      ir_s1 <= bus.ir_rx;
      ir_s  <= ir_s1;
      if (!act || blk)     fcnt <= '0;
      else if (fcnt != FMAX) fcnt <= fcnt + 1'b1;
      rx_cnt <= (detect || rx_tick) ? 16'd0 : rx_cnt + 16'd1;
      // a fresh detect restarts the 16-tick low window and beats expiry
      if (detect) begin
        rx_q <= 1'b0;
        win  <= 4'd0;
      end else if (!rx_q && rx_tick) begin
        if (win == 4'd15) rx_q <= 1'b1;
        else              win  <= win + 4'd1;
      end
    end
  end

  assign bus.ir_tx   = ir_tx_q;
  assign bus.tx_busy = busy_q;
  assign bus.rx_nrz  = rx_q;
endmodule

// File: tb/tb_irda_sir_codec.sv
// Directed bench for irda_sir_codec: cycle-by-cycle model of pulse timing plus hand-picked points.
module tb_irda_sir_codec;
  logic clk = 1'b0;
  logic reset;
  logic loop, ir_rx_drv;
  always #5 clk = ~clk;

  irda_sir_if bus ();
  assign bus.ir_rx = loop ? ~bus.ir_tx : ir_rx_drv;

  irda_sir_codec dut (.clk(clk), .reset(reset), .bus(bus));

  int compared = 0, mismatched = 0;
  logic txl [0:2047];
  logic rxl [0:2047];
  logic exa [0:2047];
  logic aa  [0:2047];
  logic obs_tx [0:2047];
  logic obs_rx [0:2047];

  function automatic logic txat(input int i);
    if (i < 0) return 1'b1;
    return txl[i];
  endfunction
  function automatic logic aat(input int i);
    if (i < 0) return 1'b0;
    return aa[i];
  endfunction

  task automatic clear_wave();
    for (int i = 0; i < 2048; i++) begin txl[i] = 1'b1; rxl[i] = 1'b1; end
  endtask

  // 8N1 frame: start, data LSB first, stop; bl clk per bit
  task automatic set_frame(input logic [7:0] d, input int bl);
    logic [9:0] f;
    f = {1'b1, d, 1'b0};
    for (int b = 0; b < 10; b++)
      for (int k = 0; k < bl; k++) txl[b*bl + k] = f[b];
  endtask

  task automatic run_wave(input string name, input int n, input int req_pulses, output int busy_hi);
    int d, s, last_det, e_tx, e_busy, e_rx, f_tx, f_busy, f_rx, pulses;
    logic prev, ex_b, er, det;
    d = (bus.div == 16'd0) ? 1 : int'(bus.div);
    s = -100000; last_det = -100000;
    e_tx = 0; e_busy = 0; e_rx = 0; f_tx = -1; f_busy = -1; f_rx = -1;
    pulses = 0; prev = 1'b0; busy_hi = 0;
    for (int t = 0; t < n; t++) begin
      @(posedge clk); #1;
      bus.tx_nrz = txl[t];
      ir_rx_drv  = rxl[t];
      @(negedge clk);
      if (txat(t-3) == 1'b0 && txat(t-4) == 1'b1) s = t - 3;
      exa[t] = (txat(t-3) == 1'b0) && (((t - 3 - s) % (16*d)) < 3*d);
      ex_b   = !txat(t-3);
      aa[t]  = loop ? exa[t] : !rxl[t];
      det    = aat(t-4) && aat(t-3) && !aat(t-5);
      if (det) last_det = t;
      er = ((t - last_det) >= 16*d);
`ifdef IRDA_ECHO_SUPPRESS_EN
      if (loop) er = 1'b1;
`endif
      obs_tx[t] = bus.ir_tx;
      obs_rx[t] = bus.rx_nrz;
      if (bus.ir_tx   !== exa[t]) begin e_tx++;   if (f_tx   < 0) f_tx   = t; end
      if (bus.tx_busy !== ex_b)   begin e_busy++; if (f_busy < 0) f_busy = t; end
      if (bus.rx_nrz  !== er)     begin e_rx++;   if (f_rx   < 0) f_rx   = t; end
      if (bus.ir_tx === 1'b1 && !prev) pulses++;
      prev = bus.ir_tx;
      if (bus.tx_busy === 1'b1) busy_hi++;
    end
    compared++;
    if (e_tx !== 0) begin mismatched++;
      $display("FAIL %s ir_tx: %0d bad cycles (first t=%0d), required 0", name, e_tx, f_tx); end
    compared++;
    if (e_busy !== 0) begin mismatched++;
      $display("FAIL %s tx_busy: %0d bad cycles (first t=%0d), required 0", name, e_busy, f_busy); end
    compared++;
    if (e_rx !== 0) begin mismatched++;
      $display("FAIL %s rx_nrz: %0d bad cycles (first t=%0d), required 0", name, e_rx, f_rx); end
    compared++;
    if (pulses !== req_pulses) begin mismatched++;
      $display("FAIL %s pulse_count: got %0d, required %0d", name, pulses, req_pulses); end
  endtask

  task automatic test_reset();
    reset = 1'b1; loop = 1'b0; bus.div = 16'd4; bus.tx_nrz = 1'b0; ir_rx_drv = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); @(negedge clk);
      compared++;
      if ({bus.ir_tx, bus.tx_busy, bus.rx_nrz} !== 3'b001) begin mismatched++;
        $display("FAIL reset_hold c=%0d: {ir_tx,busy,rx}=%b, required 001", c,
                 {bus.ir_tx, bus.tx_busy, bus.rx_nrz}); end
    end
    bus.tx_nrz = 1'b1; ir_rx_drv = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (20) @(posedge clk);
  endtask

  task automatic test_tx_55();
    int bh;
    int   ix [4] = '{2, 3, 14, 15};
    logic rq [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    clear_wave(); set_frame(8'h55, 64); bus.div = 16'd4;
    run_wave("tx_55", 740, 5, bh);
    for (int i = 0; i < 4; i++) begin
      compared++;
      if (obs_tx[ix[i]] !== rq[i]) begin mismatched++;
        $display("FAIL tx_55_edge t=%0d: ir_tx=%b, required %b", ix[i], obs_tx[ix[i]], rq[i]); end
    end
  endtask

  task automatic test_tx_00();
    int bh;
    clear_wave(); set_frame(8'h00, 64); bus.div = 16'd4;
    run_wave("tx_00", 740, 9, bh);
    compared++;
    if (bh !== 576) begin mismatched++;
      $display("FAIL tx_00_busy_len: got %0d clk, required 576", bh); end
  endtask

  task automatic test_tx_break();
    int bh;
    clear_wave(); bus.div = 16'd4;
    for (int i = 0; i < 640; i++) txl[i] = 1'b0;
    run_wave("tx_break", 740, 10, bh);
    compared++;
    if (obs_tx[67] !== 1'b1 || obs_tx[579] !== 1'b1 || obs_tx[591] !== 1'b0) begin mismatched++;
      $display("FAIL tx_break_spacing: ir_tx@67,579,591=%b%b%b, required 110",
               obs_tx[67], obs_tx[579], obs_tx[591]); end
  endtask

  task automatic test_rx_55();
    int bh;
    int   ix [4] = '{3, 4, 67, 68};
    logic rq [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    clear_wave(); bus.div = 16'd4; loop = 1'b0;
    for (int b = 0; b < 10; b += 2)
      for (int k = 0; k < 12; k++) rxl[b*64 + k] = 1'b0;
    run_wave("rx_55", 740, 0, bh);
    for (int i = 0; i < 4; i++) begin
      compared++;
      if (obs_rx[ix[i]] !== rq[i]) begin mismatched++;
        $display("FAIL rx_55_edge t=%0d: rx_nrz=%b, required %b", ix[i], obs_rx[ix[i]], rq[i]); end
    end
  endtask

  task automatic test_rx_glitch();
    int bh;
    int   ix [5] = '{13, 103, 104, 167, 168};
    logic rq [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    clear_wave(); bus.div = 16'd4; loop = 1'b0;
    rxl[10] = 1'b0;
    rxl[100] = 1'b0; rxl[101] = 1'b0;
    run_wave("rx_glitch", 220, 0, bh);
    for (int i = 0; i < 5; i++) begin
      compared++;
      if (obs_rx[ix[i]] !== rq[i]) begin mismatched++;
        $display("FAIL rx_glitch t=%0d: rx_nrz=%b, required %b", ix[i], obs_rx[ix[i]], rq[i]); end
    end
  endtask

  task automatic test_loopback();
    int bh;
    clear_wave(); set_frame(8'h00, 64); bus.div = 16'd4; loop = 1'b1;
    run_wave("loopback", 740, 9, bh);
    loop = 1'b0;
`ifdef IRDA_ECHO_SUPPRESS_EN
    compared++;
    if (obs_rx[7] !== 1'b1 || obs_rx[300] !== 1'b1 || obs_rx[640] !== 1'b1) begin mismatched++;
      $display("FAIL loopback_suppress: rx@7,300,640=%b%b%b, required 111",
               obs_rx[7], obs_rx[300], obs_rx[640]); end
`else
    compared++;
    if ({obs_rx[6], obs_rx[7], obs_rx[582], obs_rx[583]} !== 4'b1001) begin mismatched++;
      $display("FAIL loopback_mirror: rx@6,7,582,583=%b%b%b%b, required 1001",
               obs_rx[6], obs_rx[7], obs_rx[582], obs_rx[583]); end
`endif
  endtask

  task automatic test_div0();
    int bh;
    clear_wave(); set_frame(8'h55, 16); bus.div = 16'd0;
    run_wave("div0", 220, 5, bh);
    compared++;
    if ({obs_tx[3], obs_tx[5], obs_tx[6]} !== 3'b110) begin mismatched++;
      $display("FAIL div0_width: ir_tx@3,5,6=%b%b%b, required 110", obs_tx[3], obs_tx[5], obs_tx[6]); end
    bus.div = 16'd4;
    repeat (40) @(posedge clk);
  endtask

  task automatic test_reset_mid();
    int hi;
    clear_wave(); set_frame(8'h00, 64); bus.div = 16'd4; loop = 1'b0;
    for (int k = 40; k < 52; k++) rxl[k] = 1'b0;
    for (int t = 0; t <= 70; t++) begin
      @(posedge clk); #1;
      if (t < 70) begin bus.tx_nrz = txl[t]; ir_rx_drv = rxl[t]; end
      else begin reset = 1'b1; bus.tx_nrz = 1'b1; ir_rx_drv = 1'b1; end
      @(negedge clk);
    end
    compared++;
    if ({bus.ir_tx, bus.rx_nrz} !== 2'b10) begin mismatched++;
      $display("FAIL reset_mid_before: {ir_tx,rx}=%b, required 10", {bus.ir_tx, bus.rx_nrz}); end
    @(posedge clk); @(negedge clk);
    compared++;
    if ({bus.ir_tx, bus.tx_busy, bus.rx_nrz} !== 3'b001) begin mismatched++;
      $display("FAIL reset_mid_after: {ir_tx,busy,rx}=%b, required 001",
               {bus.ir_tx, bus.tx_busy, bus.rx_nrz}); end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    hi = 0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (bus.ir_tx !== 1'b0 || bus.tx_busy !== 1'b0 || bus.rx_nrz !== 1'b1) hi++;
    end
    compared++;
    if (hi !== 0) begin mismatched++;
      $display("FAIL reset_mid_quiet: %0d active cycles after release, required 0", hi); end
  endtask

  initial begin
    reset = 1'b1; loop = 1'b0; ir_rx_drv = 1'b1; bus.div = 16'd4; bus.tx_nrz = 1'b1;
    test_reset();
    test_tx_55();
    test_tx_00();
    test_tx_break();
    test_rx_55();
    test_rx_glitch();
    test_loopback();
    test_div0();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
